// File: rtl/audio_nios_pio_pkg.sv
// Shared definitions for the audio Nios bidirectional PIO: register map and edge modes.
package audio_nios_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/audio_nios_pio_sync.sv
// Pad input synchroniser: a reset-to-0 flop chain plus one delayed copy for edge detection.
module audio_nios_pio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] prev_in
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_r;
    logic [WIDTH-1:0]                  prev_r;

    // Shift the raw pad through the chain and keep the previous synchronised value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_r <= {(SYNC_STAGES*WIDTH){1'b0}};
            prev_r  <= {WIDTH{1'b0}};
        end else begin
            chain_r[0] <= pad_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
            prev_r <= chain_r[SYNC_STAGES-1];
        end
    end

    assign sync_in = chain_r[SYNC_STAGES-1];
    assign prev_in = prev_r;

endmodule

// File: rtl/audio_nios_bidir_pio.sv
// Avalon-MM bidirectional PIO: per-pin direction, synchronised input, edge capture and irq,
// with atomic set/clear of the output register.
module audio_nios_bidir_pio #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] RESET_OUT   = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] RESET_DIR   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] bidir_port
);

    import audio_nios_pio_pkg::*;

    localparam logic [2:0] WARM_CYCLES = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] data_out_r;
    logic [WIDTH-1:0] data_dir_r;
    logic [WIDTH-1:0] irq_mask_r;
    logic [WIDTH-1:0] edge_cap_r;
    logic [2:0]       warm_cnt_r;

    logic [WIDTH-1:0] pad_s;
    logic [WIDTH-1:0] sync_in_s;
    logic [WIDTH-1:0] prev_in_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] wd_s;
    logic [WIDTH-1:0] cap_clr_s;
    logic [WIDTH-1:0] cap_set_s;
    logic [WIDTH-1:0] edge_cap_nxt_s;
    logic [31:0]      rd_nxt_s;
    logic             wr_s;
    logic             warm_active_s;
    logic             unused_wd_s;

    assign wr_s          = chipselect & ~write_n;
    assign wd_s          = writedata[WIDTH-1:0];
    assign unused_wd_s   = ^writedata;
    assign warm_active_s = (warm_cnt_r < WARM_CYCLES);

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign bidir_port[g] = data_dir_r[g] ? data_out_r[g] : 1'bz;
    end

    // Sampled regardless of direction so driven pins read back their own level.
    assign pad_s = bidir_port;

    audio_nios_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pad_in  (pad_s),
        .sync_in (sync_in_s),
        .prev_in (prev_in_s)
    );

    // Edge term selected by the configured capture mode.
    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: edge_s = sync_in_s & ~prev_in_s;
            EDGE_FALL: edge_s = ~sync_in_s & prev_in_s;
            default:   edge_s = sync_in_s ^ prev_in_s;
        endcase
    end

    // Next edge capture state; a new edge outranks a simultaneous write-clear.
    always_comb begin
        cap_clr_s = {WIDTH{1'b0}};
        cap_set_s = {WIDTH{1'b0}};
        if (wr_s && (address == ADDR_EDGE_CAP)) begin
            cap_clr_s = wd_s;
        end else begin
            cap_clr_s = {WIDTH{1'b0}};
        end
        if (warm_active_s) begin
            cap_set_s = {WIDTH{1'b0}};
        end else begin
            cap_set_s = edge_s;
        end
        edge_cap_nxt_s = (edge_cap_r & ~cap_clr_s) | cap_set_s;
    end

    // Read mux, registered every cycle regardless of chipselect.
    always_comb begin
        rd_nxt_s = 32'd0;
        case (address)
            ADDR_DATA:     rd_nxt_s[WIDTH-1:0] = sync_in_s;
            ADDR_DIR:      rd_nxt_s[WIDTH-1:0] = data_dir_r;
            ADDR_IRQ_MASK: rd_nxt_s[WIDTH-1:0] = irq_mask_r;
            ADDR_EDGE_CAP: rd_nxt_s[WIDTH-1:0] = edge_cap_r;
            default:       rd_nxt_s = 32'd0;
        endcase
    end

    // Firmware-visible control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_r <= RESET_OUT;
            data_dir_r <= RESET_DIR;
            irq_mask_r <= {WIDTH{1'b0}};
        end else if (wr_s) begin
            case (address)
                ADDR_DATA:     data_out_r <= wd_s;
                ADDR_DIR:      data_dir_r <= wd_s;
                ADDR_IRQ_MASK: irq_mask_r <= wd_s;
                ADDR_OUT_SET:  data_out_r <= data_out_r | wd_s;
                ADDR_OUT_CLR:  data_out_r <= data_out_r & ~wd_s;
                default:       data_out_r <= data_out_r;
            endcase
        end else begin
            data_out_r <= data_out_r;
        end
    end

    // Warm-up counter suppresses false edges while the synchroniser fills after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt_r <= 3'd0;
        end else if (warm_active_s) begin
            warm_cnt_r <= warm_cnt_r + 3'd1;
        end else begin
            warm_cnt_r <= warm_cnt_r;
        end
    end

    // Edge capture and read data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap_r <= {WIDTH{1'b0}};
            readdata   <= 32'd0;
        end else begin
            edge_cap_r <= edge_cap_nxt_s;
            readdata   <= rd_nxt_s;
        end
    end

    assign irq = |(edge_cap_r & irq_mask_r);

endmodule
